// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   GLYPHS      : active-high segment patterns (bit 0 = a ... bit 6 = g) for hex 0..F
//   GLYPH_BLANK : all segments dark
//   clog2()     : counter width helper, never returns less than 1 bit
package seven_seg_pkg;

    // Entry [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Width needed to count 0..n-1; a single-value counter still gets one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : hex digit to show
//   blank  : 1 forces every segment dark
//   glyph  : active-high segments, bit 0 = a ... bit 6 = g
module hex_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);

    assign glyph = blank ? GLYPH_BLANK : GLYPHS[nibble];

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit seven-segment display driver with tear-free updates.
//   Clk, Reset      : clock, asynchronous active-high reset
//   Enable          : 1 = scan, 0 = display dark with prescaler/index held
//   Load, Din, DpIn : strobe capturing hex nibbles and decimal points
//   BlankLz         : blank leading zero digits (digit 0 always shown)
//   Seg, Dp, An     : registered segment, decimal point and anode pins
//   FrameTick       : one-cycle pulse the cycle after each frame boundary
module seven_segment_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic [DIGITS-1:0]     DpIn,
    input  logic                  BlankLz,
    output logic [6:0]            Seg,
    output logic                  Dp,
    output logic [DIGITS-1:0]     An,
    output logic                  FrameTick
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int PRE_W = clog2(CLK_DIV);

    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [4*DIGITS-1:0] shadow, disp;
    logic [DIGITS-1:0]   shadow_dp, disp_dp;

    logic pre_tc, idx_last, boundary;

    assign pre_tc   = (pre == PRE_W'(CLK_DIV - 1));
    assign idx_last = (idx == IDX_W'(DIGITS - 1));
    assign boundary = Enable & pre_tc & idx_last;

    // Prescaler and digit index; both freeze while Enable is low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre       <= '0;
            idx       <= '0;
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= boundary;
            if (Enable) begin
                if (pre_tc) begin
                    pre <= '0;
                    idx <= idx_last ? '0 : idx + 1'b1;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

    // Double buffer: a load on the boundary cycle bypasses the shadow so it
    // lands in the very next frame instead of waiting a whole frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow    <= '0;
            shadow_dp <= '0;
            disp      <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
        end else begin
            if (Load) begin
                shadow    <= Din;
                shadow_dp <= DpIn;
            end
            if (boundary && Load) begin
                disp    <= Din;
                disp_dp <= DpIn;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
                pending <= 1'b0;
            end else if (Load) begin
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero mask: zero_above[k] means digits DIGITS-1..k are all zero.
    logic [DIGITS-1:0] zero_above;
    logic [DIGITS-1:0] onehot;
    logic [3:0]        sel_nib;
    logic              sel_dp;
    logic              sel_blank;
    logic              run;

    always_comb begin
        zero_above = '0;
        onehot     = '0;
        sel_nib    = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        run        = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run           = run & (disp[4*k +: 4] == 4'h0);
            zero_above[k] = run;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                onehot[k] = 1'b1;
                sel_nib   = disp[4*k +: 4];
                sel_dp    = disp_dp[k];
                sel_blank = (k != 0) && zero_above[k];
            end
        end
    end

    logic [6:0] glyph;

    hex_seg_decode u_dec (
        .nibble (sel_nib),
        .blank  (BlankLz & sel_blank),
        .glyph  (glyph)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An  <= AN_OFF;
            Seg <= SEG_OFF;
            Dp  <= DP_OFF;
        end else if (Enable) begin
            An  <= AN_ACTIVE_LOW  ? ~onehot : onehot;
            Seg <= SEG_ACTIVE_LOW ? ~glyph  : glyph;
            Dp  <= SEG_ACTIVE_LOW ? ~sel_dp : sel_dp;
        end else begin
            An  <= AN_OFF;
            Seg <= SEG_OFF;
            Dp  <= DP_OFF;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Din = '0;
    logic [3:0]  DpIn = '0;
    logic        BlankLz = 1'b0;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  An;
    logic        FrameTick;

    seven_segment_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load(Load),
        .Din(Din), .DpIn(DpIn), .BlankLz(BlankLz),
        .Seg(Seg), .Dp(Dp), .An(An), .FrameTick(FrameTick)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: scan position is simply the count of enabled cycles
    // since reset modulo the frame length.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          ecount;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_disp_dp, m_shadow_dp;
    bit          m_pending;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;

    task automatic model_reset();
        ecount = 0;
        m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0;
        m_pending = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    endtask

    function automatic int pos();
        return ecount % FRAME;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare on the falling edge.
    task automatic step(input bit en, input bit ld, input logic [15:0] din,
                        input logic [3:0] dpin, input bit blz);
        int  p, d;
        bit  bnd, blank;
        Enable = en; Load = ld; Din = din; DpIn = dpin; BlankLz = blz;
        @(posedge Clk);
        p = pos();
        d = p / CLK_DIV;
        if (en) begin
            blank = blz && d > 0 && ((m_disp >> (4 * d)) == 0);
            e_an  = ~(4'b0001 << d);
            e_seg = blank ? 7'h7F : ~glyph_tab[(m_disp >> (4 * d)) & 16'hF];
            e_dp  = ~m_disp_dp[d];
        end else begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end
        bnd    = en && (p == FRAME - 1);
        e_tick = bnd;
        if (bnd && ld) begin
            m_disp = din; m_disp_dp = dpin; m_pending = 0;
        end else if (bnd && m_pending) begin
            m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pending = 0;
        end else if (ld) begin
            m_pending = 1;
        end
        if (ld) begin
            m_shadow = din; m_shadow_dp = dpin;
        end
        if (en) ecount++;
        @(negedge Clk);
        check("an", 16'(An), 16'(e_an));
        check("seg", 16'(Seg), 16'(e_seg));
        check("dp", 16'(Dp), 16'(e_dp));
        check("tick", 16'(FrameTick), 16'(e_tick));
    endtask

    task automatic run(input int n, input bit en, input bit blz);
        for (int i = 0; i < n; i++) step(en, 0, '0, '0, blz);
    endtask

    task automatic run_to(input int p, input bit blz);
        for (int i = 0; i < FRAME && pos() != p; i++) step(1, 0, '0, '0, blz);
        check("run_to_pos", 16'(pos()), 16'(p));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 16'(An), 16'hF);
        check({tag, "_seg"}, 16'(Seg), 16'h7F);
        check({tag, "_dp"}, 16'(Dp), 16'h1);
        check({tag, "_tick"}, 16'(FrameTick), 16'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge Clk);
        check_reset_outputs("rst");
        Reset = 1'b0;

        // free-running scan of the all-zero display
        run(2 * FRAME + 3, 1, 0);

        // load mid-frame, shows from next frame
        run_to(6, 0);
        step(1, 1, 16'h12AF, 4'b0100, 0);
        run(2 * FRAME, 1, 0);

        // leading-zero blanking
        step(1, 1, 16'h0050, 4'b0000, 1);
        run(2 * FRAME, 1, 1);
        step(1, 1, 16'h0000, 4'b0000, 1);
        run(2 * FRAME, 1, 1);

        // load on the boundary cycle, then a second load right after
        run_to(FRAME - 1, 0);
        step(1, 1, 16'hA5C3, 4'b1001, 0);
        step(1, 1, 16'h1234, 4'b0010, 0);
        run(2 * FRAME + 2, 1, 0);

        // disable mid-slot, then resume
        run_to(5, 0);
        run(5, 0, 0);
        run(FRAME + 4, 1, 0);

        // async reset mid-frame after a load: data must never appear
        run_to(9, 0);
        step(1, 1, 16'h9999, 4'b1111, 0);
        run(2, 1, 0);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("rst_hold");
        model_reset();
        Reset = 1'b0;
        run(2 * FRAME, 1, 0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'h0;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, d,
                 4'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
